cfu_word_unpacker: RTL and testbench

CFU_WORD_UNPACKER -- requirements
Module: cfu_word_unpacker

---
 rtl/cfu_unpack_pkg.sv | 18 +
 rtl/cfu_lane_offset_add.sv | 18 +
 rtl/cfu_word_unpacker.sv | 120 ++++++++++++
 tb/tb_cfu_word_unpacker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_unpack_pkg.sv
// Shared types and lane geometry for the CFU word unpacker.
// Used by cfu_word_unpacker (optional offset feature: CFU_UNPACK_OFFSET_EN).
package cfu_unpack_pkg;

    localparam int LANES    = 4;
    localparam int LANE_W   = 10;
    localparam int OFFSET_W = 9;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETTLE,
        ST_VALID,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cfu_lane_offset_add.sv
// One unpacked lane: sign-extend a buffer byte and add a signed offset.
// Purely combinational; the sum always fits in LANE_W bits, so no saturation.
module cfu_lane_offset_add
    import cfu_unpack_pkg::*;
(
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic [OFFSET_W-1:0] offset,
    output logic [LANE_W-1:0]   lane
);

    logic [LANE_W-1:0] byte_ext;
    logic [LANE_W-1:0] offset_ext;

    assign byte_ext   = {{(LANE_W-BYTE_W){byte_in[BYTE_W-1]}}, byte_in};
    assign offset_ext = {{(LANE_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    assign lane       = byte_ext + offset_ext;

endmodule

// File: rtl/cfu_word_unpacker.sv
// Pops int8x4 words from a registered-output buffer and emits four 10-bit lanes.
// Define CFU_UNPACK_OFFSET_EN to add the latched input_offset to every lane.
module cfu_word_unpacker
    import cfu_unpack_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 9
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         num_words,
    input  logic [OFFSET_W-1:0]      input_offset,
    output logic                     buf_read_en,
    input  logic [WORD_W-1:0]        buf_read_data,
    input  logic                     buf_read_empty,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*LANE_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

`ifdef CFU_UNPACK_OFFSET_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          remaining;
    logic [OFFSET_W-1:0]       offset_q;
    logic [OFFSET_W-1:0]       offset_eff;
    logic [LANES*LANE_W-1:0]   lanes;
    logic                      last_word;
    logic                      handshake;

    assign offset_eff = OFFSET_EN ? offset_q : '0;
    assign last_word  = (remaining == CNT_W'(1));
    // Abort wins over a coincident handshake, so the buffer is never popped on abort.
    assign handshake  = (state == ST_VALID) && out_ready && !abort;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cfu_lane_offset_add u_add (
            .byte_in (buf_read_data[BYTE_W*i +: BYTE_W]),
            .offset  (offset_eff),
            .lane    (lanes[LANE_W*i +: LANE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            offset_q  <= '0;
        end else if ((state == ST_IDLE) && start && !abort) begin
            remaining <= num_words;
            offset_q  <= input_offset;
        end else if (handshake) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // SETTLE gives the registered buffer output one cycle to catch up with its count.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = (num_words == '0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!buf_read_empty) begin
                        state_next = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    state_next = buf_read_empty ? ST_WAIT : ST_VALID;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        state_next = last_word ? ST_DONE : ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Lane data stays stable in VALID because the buffer head only moves on our pop.
    always_comb begin
        out_valid   = (state == ST_VALID);
        out_last    = (state == ST_VALID) && last_word;
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        buf_read_en = handshake;
        out_data    = (state == ST_VALID) ? lanes : '0;
    end

endmodule

// File: tb/tb_cfu_word_unpacker.sv
// Self-checking bench for cfu_word_unpacker with a queue-based buffer and lane model.
// Honours CFU_UNPACK_OFFSET_EN when computing expected lanes.
module tb_cfu_word_unpacker;

    localparam int CNT_W = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic [8:0]  input_offset = '0;
    logic        buf_read_en;
    logic [31:0] buf_read_data = 32'h0;
    logic        buf_read_empty = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int pops_on_empty = 0;

    logic [31:0] fifo[$];
    logic [31:0] job_words[$];
    logic        push_en = 1'b0;
    logic [31:0] push_word = 32'h0;

    cfu_word_unpacker #(.WORD_W(32), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .num_words      (num_words),
        .input_offset   (input_offset),
        .buf_read_en    (buf_read_en),
        .buf_read_data  (buf_read_data),
        .buf_read_empty (buf_read_empty),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer whose empty flag tracks the count at once but whose data lags one cycle.
    always @(posedge clk) begin
        buf_read_data <= (fifo.size() > 0) ? fifo[0] : 32'h0;
        if (buf_read_en) begin
            pops++;
            if (fifo.size() == 0) pops_on_empty++;
            else void'(fifo.pop_front());
        end
        if (push_en) fifo.push_back(push_word);
        buf_read_empty <= (fifo.size() == 0);
    end

    function automatic logic [39:0] expectedLanes(input logic [31:0] word, input int off);
        logic [39:0] r;
        logic [7:0]  b;
        int          v;
        int          eff;
        logic [8:0]  off9;
        off9 = off[8:0];
`ifdef CFU_UNPACK_OFFSET_EN
        eff = int'($signed(off9));
`else
        eff = 0;
`endif
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b = word[8*i +: 8];
            v = int'($signed(b)) + eff;
            r[10*i +: 10] = v[9:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input int n, input int off, input logic rdy);
        start        = s;
        abort        = a;
        num_words    = n[CNT_W-1:0];
        input_offset = off[8:0];
        out_ready    = rdy;
    endtask

    task automatic flushBuffer();
        push_en = 1'b0;
        fifo.delete();
        tick();
        tick();
    endtask

    task automatic preload();
        foreach (job_words[i]) fifo.push_back(job_words[i]);
        tick();
        tick();
    endtask

    // Runs one job from job_words; pushAt>=0 streams one word at that loop step,
    // streamPct>0 streams randomly, otherwise the buffer is assumed preloaded.
    task automatic runJob(input string name, input int n, input int off, input int readyPct,
                          input int streamPct, input int pushAt, input int holdCycles,
                          input bit checkRate, input int maxCycles);
        int hs = 0;
        int pushed = 0;
        int p0;
        int busyCycles = 0;
        int lastHsCyc = -100;
        int fallCyc = -1;
        int startCyc = 0;
        int validSeen = 0;
        bit doneSeen = 1'b0;
        bit firstValid = 1'b1;
        logic prevEmpty;
        logic rdy;
        p0 = pops;
        prevEmpty = buf_read_empty;
        for (int k = 0; k < maxCycles && !doneSeen; k++) begin
            rdy = ($urandom_range(99) < readyPct);
            if (out_valid && validSeen < holdCycles) rdy = 1'b0;
            applyStimulus(k == 0, 1'b0, n, off, rdy);
            if (k == 0) startCyc = cyc;
            push_en = 1'b0;
            if (pushed < n && ((pushAt >= 0 && k == pushAt) ||
                               (pushAt < 0 && streamPct > 0 && $urandom_range(99) < streamPct))) begin
                push_en   = 1'b1;
                push_word = job_words[pushed];
                pushed++;
            end
            #1;
            if (!buf_read_empty && prevEmpty) fallCyc = cyc;
            prevEmpty = buf_read_empty;
            if (out_valid) begin
                if (firstValid && fallCyc >= 0)
                    checkOutput({name, " first valid latency"}, 64'((cyc - fallCyc) >= 2), 64'd1);
                firstValid = 1'b0;
                if (hs < n) begin
                    checkOutput({name, " lanes"}, out_data, expectedLanes(job_words[hs], off));
                    checkOutput({name, " last"}, out_last, hs == n - 1);
                end else begin
                    checkOutput({name, " extra valid"}, hs, n - 1);
                end
                validSeen++;
            end
            checkOutput({name, " pop only on handshake"}, buf_read_en, out_valid && out_ready);
            if (done) begin
                checkOutput({name, " done timing"}, cyc, (n == 0) ? startCyc + 1 : lastHsCyc + 1);
                doneSeen = 1'b1;
            end
            if (busy) busyCycles++;
            if (out_valid && out_ready) begin
                if (checkRate && hs > 0)
                    checkOutput({name, " handshake spacing"}, cyc - lastHsCyc, 2);
                lastHsCyc = cyc;
                hs++;
            end
            tick();
        end
        push_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput({name, " done seen before timeout"}, doneSeen, 1'b1);
        checkOutput({name, " handshakes"}, hs, n);
        checkOutput({name, " pops"}, pops - p0, n);
        checkOutput({name, " pops on empty"}, pops_on_empty, 0);
        checkOutput({name, " idle after done busy"}, busy, 1'b0);
        checkOutput({name, " idle after done pulse"}, done, 1'b0);
        if (n == 0) checkOutput({name, " busy cycles"}, busyCycles, 1);
    endtask

    task automatic waitValid(input string name);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        checkOutput({name, " reached VALID"}, out_valid, 1'b1);
    endtask

    initial begin
        int p0;
        int doneCount;
        int roff;

        $display("[TB] reset");
        rst = 1'b1;
        tick(); tick(); tick();
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset buf_read_en", buf_read_en, 1'b0);
        checkOutput("reset out_last", out_last, 1'b0);
        checkOutput("reset out_data", out_data, 40'h0);
        rst = 1'b0;
        tick();

        $display("[TB] two-word preloaded job");
        job_words = {32'h80FF7F01, 32'h00000000};
        preload();
        runJob("two_word", 2, 128, 100, 0, -1, 0, 1'b1, 40);
        flushBuffer();

        $display("[TB] zero-word job");
        job_words.delete();
        runJob("zero_word", 0, 3, 100, 0, -1, 0, 1'b0, 10);

        $display("[TB] late word with stalled consumer");
        job_words = {$urandom()};
        runJob("late_word", 1, -7, 100, 0, 10, 5, 1'b0, 60);
        flushBuffer();

        $display("[TB] negative byte with offset");
        job_words = {32'h000000FE};
        preload();
        runJob("byte_fe", 1, 50, 100, 0, -1, 0, 1'b0, 20);
        flushBuffer();

        $display("[TB] 256-word streamed job");
        job_words.delete();
        for (int i = 0; i < 256; i++) job_words.push_back($urandom());
        roff = int'($urandom_range(255)) - 128;
        runJob("stream256", 256, roff, 60, 40, -1, 0, 1'b0, 6000);
        flushBuffer();

        $display("[TB] abort coincident with handshake");
        job_words = {32'h12345678};
        preload();
        p0 = pops;
        applyStimulus(1'b1, 1'b0, 3, 5, 1'b0);
        tick();
        start = 1'b0;
        waitValid("abort");
        applyStimulus(1'b0, 1'b1, 3, 5, 1'b1);
        #1;
        checkOutput("abort pop suppressed", buf_read_en, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("abort out_valid", out_valid, 1'b0);
        checkOutput("abort busy", busy, 1'b0);
        doneCount = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) doneCount++;
            tick();
        end
        checkOutput("abort no done", doneCount, 0);
        checkOutput("abort no pop", pops - p0, 0);

        $display("[TB] start with abort in IDLE");
        applyStimulus(1'b1, 1'b1, 2, 0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("start+abort stays idle", busy, 1'b0);
        flushBuffer();

        $display("[TB] reset mid-job");
        job_words = {32'hCAFEF00D, 32'h01020304};
        preload();
        applyStimulus(1'b1, 1'b0, 2, 9, 1'b0);
        tick();
        start = 1'b0;
        waitValid("midreset");
        rst = 1'b1;
        tick();
        checkOutput("midreset out_valid", out_valid, 1'b0);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset done", done, 1'b0);
        checkOutput("midreset buf_read_en", buf_read_en, 1'b0);
        checkOutput("midreset out_last", out_last, 1'b0);
        checkOutput("midreset out_data", out_data, 40'h0);
        rst = 1'b0;
        flushBuffer();

        $display("[TB] random job after reset");
        job_words.delete();
        for (int i = 0; i < 5; i++) job_words.push_back($urandom());
        roff = int'($urandom_range(255)) - 128;
        runJob("random5", 5, roff, 70, 50, -1, 0, 1'b0, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
